// File: rtl/triple_bit_framer_if.sv
// triple_bit_framer_if: serial-in handshake, frame output and counters of the 3-bit framer
interface triple_bit_framer_if #(
    parameter int CNT_W = 8
);
    logic             bit_in;
    logic             bit_valid;
    logic             bit_ready;
    logic             x;
    logic             y;
    logic             z;
    logic             out_valid;
    logic             out_ready;
    logic             abort_pulse;
    logic [CNT_W-1:0] frame_count;
    logic [CNT_W-1:0] abort_count;

    modport master (
        output bit_in, bit_valid, out_ready,
        input  bit_ready, x, y, z, out_valid, abort_pulse, frame_count, abort_count
    );

    modport slave (
        input  bit_in, bit_valid, out_ready,
        output bit_ready, x, y, z, out_valid, abort_pulse, frame_count, abort_count
    );
endinterface

// File: rtl/triple_bit_framer.sv
// triple_bit_framer: packs a serial bit stream into held x/y/z frames with stall timeout and counters
module triple_bit_framer #(
    parameter int X_FIRST = 1,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    triple_bit_framer_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] X_IDX = (X_FIRST != 0) ? 2'd0 : 2'd2;
    localparam logic [1:0] Z_IDX = (X_FIRST != 0) ? 2'd2 : 2'd0;

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t        state, state_nxt;
    logic [1:0]    idx;
    logic [TW-1:0] timer;
    logic          accept, deliver, mid, expire;

    assign bus.bit_ready = (state == COLLECT) & rst_n;
    assign bus.out_valid = (state == HOLD);

    // per-cycle events and next state; an accepted bit always beats a timeout
    always_comb begin
        accept    = bus.bit_valid & (state == COLLECT);
        deliver   = (state == HOLD) & bus.out_ready;
        mid       = (state == COLLECT) & ((idx == 2'd1) | (idx == 2'd2));
        expire    = mid & ~accept & (timer >= TW'(TIMEOUT - 1));
        state_nxt = (accept & (idx == 2'd2)) ? HOLD : deliver ? COLLECT : state;
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= COLLECT;
        else        state <= state_nxt;
    end

    // slot writes, bit index, idle timer, abort pulse and counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx             <= 2'd0;
            timer           <= '0;
            bus.x           <= 1'b0;
            bus.y           <= 1'b0;
            bus.z           <= 1'b0;
            bus.abort_pulse <= 1'b0;
            bus.frame_count <= '0;
            bus.abort_count <= '0;
        end else begin
            bus.abort_pulse <= expire;
            if (accept) begin
                if (idx == X_IDX) bus.x <= bus.bit_in;
                if (idx == 2'd1)  bus.y <= bus.bit_in;
                if (idx == Z_IDX) bus.z <= bus.bit_in;
                idx   <= (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
                timer <= '0;
            end else if (expire) begin
                idx             <= 2'd0;
                timer           <= '0;
                bus.abort_count <= (&bus.abort_count) ? bus.abort_count : bus.abort_count + CNT_W'(1);
            end else if (mid) begin
                timer <= timer + TW'(1);
            end else begin
                timer <= '0;
                if (idx == 2'd3) idx <= 2'd0;
            end
            if (deliver) bus.frame_count <= bus.frame_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_triple_bit_framer.sv
// tb_triple_bit_framer: scoreboard bench for both bit orders of the 3-bit framer
module tb_triple_bit_framer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    triple_bit_framer_if #(.CNT_W(8)) a ();
    triple_bit_framer_if #(.CNT_W(8)) b ();

    assign b.bit_in    = a.bit_in;
    assign b.bit_valid = a.bit_valid;
    assign b.out_ready = a.out_ready;

    triple_bit_framer #(.X_FIRST(1), .TIMEOUT(16), .CNT_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a));
    triple_bit_framer #(.X_FIRST(0), .TIMEOUT(16), .CNT_W(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b));

    int         checks = 0;
    int         errs = 0;
    int         n_abort = 0;
    logic [7:0] exp_fc = 8'd0;
    logic [7:0] fc0;
    logic [2:0] mf;
    logic [2:0] q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard: compare both DUTs whenever a frame is handed over
    always @(negedge clk) begin
        if (rst_n && a.abort_pulse) n_abort++;
        if (rst_n && a.out_valid && a.out_ready) begin
            if (q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                mf = q.pop_front();
                check("sb_a_xyz", {29'd0, a.x, a.y, a.z}, {29'd0, mf});
                check("sb_b_xyz", {29'd0, b.x, b.y, b.z}, {29'd0, mf[0], mf[1], mf[2]});
                check("sb_b_valid", {31'd0, b.out_valid}, 32'd1);
            end
            exp_fc++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic bv);
        bit ok;
        ok = 1'b0;
        a.bit_valid = 1'b1;
        a.bit_in    = bv;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (a.bit_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("bit_ready_wait", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        a.bit_valid = 1'b0;
    endtask

    task automatic send_frame(input logic b0, input logic b1, input logic b2);
        q.push_back({b0, b1, b2});
        send_bit(b0);
        send_bit(b1);
        send_bit(b2);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        q.delete();
        exp_fc  = 8'd0;
        n_abort = 0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_outs"}, {27'd0, a.x, a.y, a.z, a.out_valid, a.abort_pulse}, 32'd0);
        check({tag, "_fc"}, {24'd0, a.frame_count}, 32'd0);
        check({tag, "_ac"}, {24'd0, a.abort_count}, 32'd0);
        check({tag, "_b_outs"}, {27'd0, b.x, b.y, b.z, b.out_valid, b.abort_pulse}, 32'd0);
    endtask

    initial begin
        a.bit_in    = 1'b0;
        a.bit_valid = 1'b0;
        a.out_ready = 1'b1;
        rst_n       = 1'b0;
        tick();
        tick();
        check("rst_bit_ready_low", {31'd0, a.bit_ready}, 32'd0);
        check_zero("rst");
        rst_n = 1'b1;
        #1;
        check("rst_bit_ready_high", {31'd0, a.bit_ready}, 32'd1);

        // 1: back-to-back 1,1,1 with consumer ready
        q.push_back(3'b111);
        send_bit(1'b1);
        send_bit(1'b1);
        check("t1_no_valid_early", {31'd0, a.out_valid}, 32'd0);
        send_bit(1'b1);
        check("t1_valid_latency", {31'd0, a.out_valid}, 32'd1);
        check("t1_xyz", {29'd0, a.x, a.y, a.z}, 32'd7);
        tick();
        check("t1_fc", {24'd0, a.frame_count}, 32'd1);
        check("t1_ready_back", {31'd0, a.bit_ready}, 32'd1);

        // 2: bit order for both settings
        send_frame(1'b1, 1'b0, 1'b0);
        check("t2_a_xyz", {29'd0, a.x, a.y, a.z}, 32'b100);
        check("t2_b_xyz", {29'd0, b.x, b.y, b.z}, 32'b001);
        tick();

        // 3: consumer stall with bits offered
        a.out_ready = 1'b0;
        send_frame(1'b1, 1'b0, 1'b1);
        a.bit_valid = 1'b1;
        a.bit_in    = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t3_ready_low", {31'd0, a.bit_ready}, 32'd0);
            check("t3_xyz_hold", {29'd0, a.x, a.y, a.z}, 32'b101);
            check("t3_valid_hold", {31'd0, a.out_valid}, 32'd1);
        end
        a.bit_valid = 1'b0;
        a.out_ready = 1'b1;
        tick();
        check("t3_fc", {24'd0, a.frame_count}, {24'd0, exp_fc});
        check("t3_ready_back", {31'd0, a.bit_ready}, 32'd1);

        // 4: two bits then 16 idle cycles abort the partial frame
        send_bit(1'b1);
        send_bit(1'b1);
        repeat (15) tick();
        check("t4_no_abort_15", {31'd0, a.abort_pulse}, 32'd0);
        check("t4_ac_15", {24'd0, a.abort_count}, 32'd0);
        tick();
        check("t4_pulse", {31'd0, a.abort_pulse}, 32'd1);
        check("t4_ac", {24'd0, a.abort_count}, 32'd1);
        tick();
        check("t4_pulse_once", {31'd0, a.abort_pulse}, 32'd0);
        repeat (20) tick();
        check("t4_n_abort", n_abort, 32'd1);
        send_frame(1'b0, 1'b1, 1'b0);
        check("t4_xyz", {29'd0, a.x, a.y, a.z}, 32'b010);
        tick();

        // 5: bit on the 16th idle cycle beats the timeout
        q.push_back(3'b101);
        send_bit(1'b1);
        repeat (15) tick();
        send_bit(1'b0);
        send_bit(1'b1);
        tick();
        check("t5_n_abort", n_abort, 32'd1);
        check("t5_ac", {24'd0, a.abort_count}, 32'd1);
        check("t5_fc", {24'd0, a.frame_count}, {24'd0, exp_fc});

        // 5b: 256 frames wrap the frame counter back to its start value
        fc0 = exp_fc;
        for (int i = 0; i < 256; i++) send_frame(1'($urandom), 1'($urandom), 1'($urandom));
        tick();
        tick();
        check("t5_wrap", {24'd0, a.frame_count}, {24'd0, fc0});

        // abort counter saturates while pulses continue
        for (int i = 0; i < 254; i++) begin
            send_bit(1'b1);
            repeat (16) tick();
        end
        check("sat_ac_255", {24'd0, a.abort_count}, 32'd255);
        send_bit(1'b0);
        repeat (17) tick();
        check("sat_ac_hold", {24'd0, a.abort_count}, 32'd255);
        check("sat_n_abort", n_abort, 32'd256);

        // 6: reset during hold, then after two bits
        a.out_ready = 1'b0;
        send_frame(1'b1, 1'b1, 1'b0);
        do_reset();
        check_zero("t6_hold");
        a.out_ready = 1'b1;
        send_bit(1'b1);
        send_bit(1'b0);
        do_reset();
        check_zero("t6_mid");
        send_frame(1'b0, 1'b1, 1'b1);
        check("t6_xyz", {29'd0, a.x, a.y, a.z}, 32'b011);
        tick();
        check("t6_fc", {24'd0, a.frame_count}, 32'd1);
        check("t6_ac", {24'd0, a.abort_count}, 32'd0);

        tick();
        check("sb_drain", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
